jtframe_debug_keys: RTL and testbench
=====================================

JTFRAME_DEBUG_KEYS -- requirements
Module: jtframe_debug_keys

Interface
REQ-001 Parameter TIMEOUT, default 65535: cycles allowed between bytes of a prefixed sequence (used only when the timeout feature is compiled in).
REQ-002 clk  input  1  single system clock; all logic on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 ps2_code  input  8  PS/2 set-2 scan byte.
REQ-005 ps2_valid  input  1  one-cycle strobe; ps2_code is valid while it is high.
REQ-006 shift  output  1  level; left shift (12) or right shift (59) held.
REQ-007 ctrl  output  1  level; left ctrl (14) or right ctrl (E0 14) held.
REQ-008 debug_plus / debug_minus  output  1 each  level; keypad + (79) / keypad - (7B) held.
REQ-009 debug_rst  output  1  level; keypad * (7C) held.
REQ-010 key_gfx  output  4  level; bits 0..3 = F9 (01), F10 (09), F11 (78), F12 (07) held.
REQ-011 key_digit  output  8  level; bits 0..7 = keys 1..8 (16,1E,26,25,2E,36,3D,3E) held.

Function
REQ-012 Parser FSM states: IDLE, EXT, BRK, EXT_BRK; it advances only on cycles where ps2_valid=1.
REQ-013 IDLE: E0 -> EXT; F0 -> BRK; any other byte -> make-event for that byte, stay IDLE.
REQ-014 EXT: F0 -> EXT_BRK; E0 -> stay EXT; other byte -> extended make-event, -> IDLE.
REQ-015 BRK: E0 -> EXT_BRK; F0 -> stay BRK; other byte -> break-event, -> IDLE.
REQ-016 EXT_BRK: E0/F0 -> stay; other byte -> extended break-event, -> IDLE.
REQ-017 Make-event sets the mapped output bit to 1; break-event clears it to 0; non-extended codes not in REQ-006..011 are ignored.
REQ-018 Extended codes other than 14 are ignored (E0 12, E0 7C from Print Screen do not touch shift/debug_rst); non-extended 14 maps only to the left-ctrl bit.
REQ-019 Left/right shift and left/right ctrl are tracked in separate internal bits; each output is the OR of its pair.
REQ-020 Bytes AA, FA, EE in IDLE are ignored with no state change.
REQ-021 Byte 00 or FF in any state is an overrun: all outputs clear to 0 on the next edge and the FSM returns to IDLE.
REQ-022 Latency: an output changes on the first rising edge after the ps2_valid cycle carrying the final byte; all outputs are registered.
REQ-023 A repeated make (typematic) of a held key leaves its output at 1 with no glitch.
REQ-024 ps2_valid held high on consecutive cycles is one byte per cycle; no byte is dropped.

Reset
REQ-025 rst_n=0 asynchronously forces FSM to IDLE and every output and internal key bit to 0, including mid-sequence; the timeout counter clears to 0.
REQ-026 The first byte after reset release is parsed from IDLE.

Configuration
REQ-027 With JTFRAME_DEBUG_KEYS_TIMEOUT_EN defined: a counter runs while the FSM is in EXT, BRK or EXT_BRK; when it reaches TIMEOUT without a new byte, the FSM returns to IDLE on the next edge, outputs unchanged; every valid byte clears the counter.
REQ-028 Without JTFRAME_DEBUG_KEYS_TIMEOUT_EN: no counter is synthesised, prefix states persist indefinitely, and TIMEOUT is ignored.

Structure
REQ-029 Scan-code constants (prefixes, overrun codes, key codes) and the FSM state encoding belong in the shared package jtframe_debug_pkg.
REQ-030 One sub-module, jtframe_debug_keymap: combinational code+extended -> {target select, valid}; the FSM and output registers stay in the top.

Verification
REQ-031 Reset, bytes 79 then F0 79 -> debug_plus 1 one edge after the first strobe, 0 one edge after the 79 that follows F0.
REQ-032 12, 59, F0 12 -> shift stays 1; then F0 59 -> shift 0.
REQ-033 E0 14 then 14 then E0 F0 14 -> ctrl 1 throughout; F0 14 -> ctrl 0; E0 12 alone -> shift remains 0.
REQ-034 16 3E 01 07 -> key_digit=81h, key_gfx=9h; then FF -> all outputs 0, FSM IDLE.
REQ-035 With macro, TIMEOUT=16: F0, 20 idle cycles, then 79 -> debug_plus 1 (break prefix discarded); without macro, same stimulus -> debug_plus stays 0.
REQ-036 rst_n low for one cycle between E0 and 14 -> ctrl 0 and the following 14 sets ctrl 1 as a plain make.

Source files
------------

// File: rtl/jtframe_debug_pkg.sv
// Shared scan-code constants, parser state encoding and key-bit layout
// for the debug keyboard decoder.
package jtframe_debug_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } state_t;

    // Prefix, overrun and keyboard housekeeping bytes
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_OVR0  = 8'h00;
    localparam logic [7:0] SC_OVR1  = 8'hFF;
    localparam logic [7:0] SC_BAT   = 8'hAA;
    localparam logic [7:0] SC_ACK   = 8'hFA;
    localparam logic [7:0] SC_ECHO  = 8'hEE;

    // Key codes (set 2)
    localparam logic [7:0] SC_SHIFT_L = 8'h12;
    localparam logic [7:0] SC_SHIFT_R = 8'h59;
    localparam logic [7:0] SC_CTRL    = 8'h14;
    localparam logic [7:0] SC_KP_PLUS = 8'h79;
    localparam logic [7:0] SC_KP_MIN  = 8'h7B;
    localparam logic [7:0] SC_KP_MUL  = 8'h7C;
    localparam logic [7:0] SC_F9      = 8'h01;
    localparam logic [7:0] SC_F10     = 8'h09;
    localparam logic [7:0] SC_F11     = 8'h78;
    localparam logic [7:0] SC_F12     = 8'h07;
    localparam logic [7:0] SC_D1      = 8'h16;
    localparam logic [7:0] SC_D2      = 8'h1E;
    localparam logic [7:0] SC_D3      = 8'h26;
    localparam logic [7:0] SC_D4      = 8'h25;
    localparam logic [7:0] SC_D5      = 8'h2E;
    localparam logic [7:0] SC_D6      = 8'h36;
    localparam logic [7:0] SC_D7      = 8'h3D;
    localparam logic [7:0] SC_D8      = 8'h3E;

    // Internal held-key bit layout
    localparam int NKEYS = 19;
    localparam int KEY_W = 5;
    typedef logic [KEY_W-1:0] key_sel_t;

    localparam key_sel_t KB_SHIFT_L = 5'd0;
    localparam key_sel_t KB_SHIFT_R = 5'd1;
    localparam key_sel_t KB_CTRL_L  = 5'd2;
    localparam key_sel_t KB_CTRL_R  = 5'd3;
    localparam key_sel_t KB_PLUS    = 5'd4;
    localparam key_sel_t KB_MINUS   = 5'd5;
    localparam key_sel_t KB_RST     = 5'd6;
    localparam key_sel_t KB_GFX0    = 5'd7;   // 7..10
    localparam key_sel_t KB_DIGIT0  = 5'd11;  // 11..18

    function automatic logic is_prefix(input logic [7:0] c);
        return (c == SC_EXT) || (c == SC_BRK);
    endfunction

    function automatic logic is_overrun(input logic [7:0] c);
        return (c == SC_OVR0) || (c == SC_OVR1);
    endfunction

    function automatic logic is_housekeeping(input logic [7:0] c);
        return (c == SC_BAT) || (c == SC_ACK) || (c == SC_ECHO);
    endfunction

endpackage

// File: rtl/jtframe_debug_keymap.sv
// Combinational map from a scan code (plus extended flag) to the internal
// held-key bit it controls. valid=0 means the code is not tracked.
module jtframe_debug_keymap
    import jtframe_debug_pkg::*;
(
    input  logic [7:0] code,
    input  logic       ext,
    output key_sel_t   sel,
    output logic       valid
);

    // Only E0 14 (right ctrl) is tracked among extended codes
    always_comb begin
        sel   = KB_SHIFT_L;
        valid = 1'b0;
        if (ext) begin
            if (code == SC_CTRL) begin
                sel   = KB_CTRL_R;
                valid = 1'b1;
            end
        end else begin
            valid = 1'b1;
            case (code)
                SC_SHIFT_L: sel = KB_SHIFT_L;
                SC_SHIFT_R: sel = KB_SHIFT_R;
                SC_CTRL:    sel = KB_CTRL_L;
                SC_KP_PLUS: sel = KB_PLUS;
                SC_KP_MIN:  sel = KB_MINUS;
                SC_KP_MUL:  sel = KB_RST;
                SC_F9:      sel = KB_GFX0;
                SC_F10:     sel = KB_GFX0 + 5'd1;
                SC_F11:     sel = KB_GFX0 + 5'd2;
                SC_F12:     sel = KB_GFX0 + 5'd3;
                SC_D1:      sel = KB_DIGIT0;
                SC_D2:      sel = KB_DIGIT0 + 5'd1;
                SC_D3:      sel = KB_DIGIT0 + 5'd2;
                SC_D4:      sel = KB_DIGIT0 + 5'd3;
                SC_D5:      sel = KB_DIGIT0 + 5'd4;
                SC_D6:      sel = KB_DIGIT0 + 5'd5;
                SC_D7:      sel = KB_DIGIT0 + 5'd6;
                SC_D8:      sel = KB_DIGIT0 + 5'd7;
                default:    valid = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/jtframe_debug_keys.sv
// PS/2 set-2 parser producing held-key levels for debug controls.
// Optional: define JTFRAME_DEBUG_KEYS_TIMEOUT_EN to abandon a prefix
// sequence (E0/F0) after TIMEOUT idle cycles.
module jtframe_debug_keys
    import jtframe_debug_pkg::*;
#(
    parameter int TIMEOUT = 65535
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ps2_code,
    input  logic       ps2_valid,
    output logic       shift,
    output logic       ctrl,
    output logic       debug_plus,
    output logic       debug_minus,
    output logic       debug_rst,
    output logic [3:0] key_gfx,
    output logic [7:0] key_digit
);

    state_t           state;
    logic [NKEYS-1:0] key_reg;
    logic [NKEYS-1:0] key_next;
    key_sel_t         map_sel;
    logic             map_valid;
    logic             in_ext;
    logic             in_brk;
    logic             code_overrun;
    logic             fire;
    logic             timed_out;

    assign in_ext       = (state == EXT) || (state == EXT_BRK);
    assign in_brk       = (state == BRK) || (state == EXT_BRK);
    assign code_overrun = is_overrun(ps2_code);

    jtframe_debug_keymap u_keymap (
        .code  (ps2_code),
        .ext   (in_ext),
        .sel   (map_sel),
        .valid (map_valid)
    );

    // A key event happens on a final (non-prefix) byte that maps to a key
    assign fire = ps2_valid && !code_overrun && !is_prefix(ps2_code) && map_valid
                  && !((state == IDLE) && is_housekeeping(ps2_code));

`ifdef JTFRAME_DEBUG_KEYS_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
    logic [CNT_W-1:0] cnt;

    // Count idle cycles spent inside a prefix sequence; any byte restarts it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (ps2_valid || state == IDLE)
            cnt <= '0;
        else if (cnt != CNT_MAX)
            cnt <= cnt + 1'b1;
    end

    assign timed_out = !ps2_valid && (state != IDLE) && (cnt == CNT_MAX);
`else
    // TIMEOUT has no effect when prefix states never expire
    logic unused_timeout;
    assign unused_timeout = TIMEOUT[0];
    assign timed_out      = 1'b0;
`endif

    // Next held-key vector: set on make, clear on break, wipe on overrun
    always_comb begin
        key_next = key_reg;
        if (ps2_valid && code_overrun)
            key_next = '0;
        else if (fire)
            key_next[map_sel] = ~in_brk;
    end

    // Held-key bits and outputs, all taken from the same next value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_reg     <= '0;
            shift       <= 1'b0;
            ctrl        <= 1'b0;
            debug_plus  <= 1'b0;
            debug_minus <= 1'b0;
            debug_rst   <= 1'b0;
            key_gfx     <= '0;
            key_digit   <= '0;
        end else begin
            key_reg     <= key_next;
            shift       <= key_next[KB_SHIFT_L] | key_next[KB_SHIFT_R];
            ctrl        <= key_next[KB_CTRL_L]  | key_next[KB_CTRL_R];
            debug_plus  <= key_next[KB_PLUS];
            debug_minus <= key_next[KB_MINUS];
            debug_rst   <= key_next[KB_RST];
            key_gfx     <= key_next[KB_GFX0 +: 4];
            key_digit   <= key_next[KB_DIGIT0 +: 8];
        end
    end

    // Prefix parser: tracks E0 / F0 context for the next byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (ps2_valid) begin
            if (code_overrun) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (ps2_code == SC_EXT)      state <= EXT;
                        else if (ps2_code == SC_BRK) state <= BRK;
                    end
                    EXT: begin
                        if (ps2_code == SC_BRK)      state <= EXT_BRK;
                        else if (ps2_code != SC_EXT) state <= IDLE;
                    end
                    BRK: begin
                        if (ps2_code == SC_EXT)      state <= EXT_BRK;
                        else if (ps2_code != SC_BRK) state <= IDLE;
                    end
                    EXT_BRK: begin
                        if (!is_prefix(ps2_code))    state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end else if (timed_out) begin
            state <= IDLE;
        end
    end

endmodule

// File: tb/tb_jtframe_debug_keys.sv
// Directed self-checking bench for jtframe_debug_keys.
module tb_jtframe_debug_keys;

    logic       clk;
    logic       rst_n;
    logic [7:0] ps2_code;
    logic       ps2_valid;
    logic       shift, ctrl, debug_plus, debug_minus, debug_rst;
    logic [3:0] key_gfx;
    logic [7:0] key_digit;
    logic [16:0] outs;

    int checks = 0;
    int errors = 0;

    assign outs = {shift, ctrl, debug_plus, debug_minus, debug_rst, key_gfx, key_digit};

    jtframe_debug_keys #(.TIMEOUT(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ps2_code    (ps2_code),
        .ps2_valid   (ps2_valid),
        .shift       (shift),
        .ctrl        (ctrl),
        .debug_plus  (debug_plus),
        .debug_minus (debug_minus),
        .debug_rst   (debug_rst),
        .key_gfx     (key_gfx),
        .key_digit   (key_digit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One strobed byte; returns #1 after the edge that consumed it
    task automatic send(input logic [7:0] c);
        ps2_code  = c;
        ps2_valid = 1'b1;
        @(posedge clk);
        #1;
        ps2_valid = 1'b0;
        ps2_code  = 8'h00;
        $display("byte %02h : shift=%0b ctrl=%0b plus=%0b minus=%0b rst=%0b gfx=%h digit=%h",
                 c, shift, ctrl, debug_plus, debug_minus, debug_rst, key_gfx, key_digit);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; ps2_valid = 1'b0; ps2_code = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (outs !== 17'h0) begin errors++; $display("FAIL reset_outs got %h want 0", outs); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (outs !== 17'h0) begin errors++; $display("FAIL post_reset_outs got %h want 0", outs); end
    endtask

    task automatic test_plus;
        send(8'h79);
        checks++;
        if (debug_plus !== 1'b1) begin errors++; $display("FAIL plus_make got %b want 1", debug_plus); end
        send(8'hF0);
        checks++;
        if (debug_plus !== 1'b1) begin errors++; $display("FAIL plus_after_f0 got %b want 1", debug_plus); end
        send(8'h79);
        checks++;
        if (debug_plus !== 1'b0) begin errors++; $display("FAIL plus_break got %b want 0", debug_plus); end
        send(8'h7B); send(8'h7C);
        checks++;
        if ({debug_minus, debug_rst} !== 2'b11) begin errors++; $display("FAIL minus_rst_make got %b want 11", {debug_minus, debug_rst}); end
        send(8'hF0); send(8'h7B);
        checks++;
        if ({debug_minus, debug_rst} !== 2'b01) begin errors++; $display("FAIL minus_break got %b want 01", {debug_minus, debug_rst}); end
        send(8'hF0); send(8'h7C);
        checks++;
        if (outs !== 17'h0) begin errors++; $display("FAIL plus_cleanup got %h want 0", outs); end
    endtask

    task automatic test_shift;
        send(8'h12); send(8'h59); send(8'hF0); send(8'h12);
        checks++;
        if (shift !== 1'b1) begin errors++; $display("FAIL shift_pair got %b want 1", shift); end
        send(8'hF0); send(8'h59);
        checks++;
        if (shift !== 1'b0) begin errors++; $display("FAIL shift_release got %b want 0", shift); end
    endtask

    task automatic test_ctrl;
        send(8'hE0); send(8'h14);
        checks++;
        if (ctrl !== 1'b1) begin errors++; $display("FAIL ctrl_right_make got %b want 1", ctrl); end
        send(8'h14);
        checks++;
        if (ctrl !== 1'b1) begin errors++; $display("FAIL ctrl_left_make got %b want 1", ctrl); end
        send(8'hE0); send(8'hF0); send(8'h14);
        checks++;
        if (ctrl !== 1'b1) begin errors++; $display("FAIL ctrl_right_break got %b want 1", ctrl); end
        send(8'hF0); send(8'h14);
        checks++;
        if (ctrl !== 1'b0) begin errors++; $display("FAIL ctrl_left_break got %b want 0", ctrl); end
        send(8'hE0); send(8'h12); send(8'hE0); send(8'h7C);
        checks++;
        if (outs !== 17'h0) begin errors++; $display("FAIL ext_ignored got %h want 0", outs); end
    endtask

    task automatic test_keys;
        send(8'h16); send(8'h3E); send(8'h01); send(8'h07);
        checks++;
        if (key_digit !== 8'h81) begin errors++; $display("FAIL key_digit got %h want 81", key_digit); end
        checks++;
        if (key_gfx !== 4'h9) begin errors++; $display("FAIL key_gfx got %h want 9", key_gfx); end
        send(8'hFF);
        checks++;
        if (outs !== 17'h0) begin errors++; $display("FAIL overrun_clear got %h want 0", outs); end
        // Overrun in the middle of a break prefix must return to IDLE
        send(8'hF0); send(8'h00); send(8'h79);
        checks++;
        if (debug_plus !== 1'b1) begin errors++; $display("FAIL overrun_idle got %b want 1", debug_plus); end
        send(8'hFF);
    endtask

    task automatic test_ignore;
        send(8'hAA); send(8'hFA); send(8'hEE);
        checks++;
        if (outs !== 17'h0) begin errors++; $display("FAIL housekeeping got %h want 0", outs); end
        send(8'h79);
        checks++;
        if (debug_plus !== 1'b1) begin errors++; $display("FAIL after_housekeeping got %b want 1", debug_plus); end
        send(8'hFF);
    endtask

    task automatic test_back_to_back;
        logic [7:0] seq [5];
        logic [7:0] exp_digit [5];
        seq       = '{8'h12, 8'h16, 8'h1E, 8'hF0, 8'h16};
        exp_digit = '{8'h00, 8'h01, 8'h03, 8'h03, 8'h02};
        ps2_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ps2_code = seq[i];
            @(posedge clk); #1;
            $display("burst byte %02h : shift=%0b digit=%h", seq[i], shift, key_digit);
            checks++;
            if (key_digit !== exp_digit[i]) begin errors++; $display("FAIL burst_digit[%0d] got %h want %h", i, key_digit, exp_digit[i]); end
        end
        // Typematic repeats of a held shift
        for (int i = 0; i < 3; i++) begin
            ps2_code = 8'h12;
            @(posedge clk); #1;
            $display("repeat byte 12 : shift=%0b", shift);
            checks++;
            if (shift !== 1'b1) begin errors++; $display("FAIL typematic[%0d] got %b want 1", i, shift); end
        end
        ps2_valid = 1'b0;
        send(8'hFF);
    endtask

    task automatic test_timeout;
        logic expect_plus;
`ifdef JTFRAME_DEBUG_KEYS_TIMEOUT_EN
        expect_plus = 1'b1;
`else
        expect_plus = 1'b0;
`endif
        send(8'hF0);
        repeat (20) @(posedge clk);
        #1;
        send(8'h79);
        checks++;
        if (debug_plus !== expect_plus) begin errors++; $display("FAIL timeout_plus got %b want %b", debug_plus, expect_plus); end
        send(8'hFF);
    endtask

    task automatic test_reset_mid;
        send(8'hE0); send(8'h14);
        send(8'hE0);
        rst_n = 1'b0;
        #1;
        checks++;
        if (ctrl !== 1'b0) begin errors++; $display("FAIL async_reset_ctrl got %b want 0", ctrl); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        send(8'h14);
        checks++;
        if (ctrl !== 1'b1) begin errors++; $display("FAIL plain_make_after_reset got %b want 1", ctrl); end
        send(8'hF0); send(8'h14);
        checks++;
        if (ctrl !== 1'b0) begin errors++; $display("FAIL left_break_after_reset got %b want 0", ctrl); end
    endtask

    initial begin
        test_reset;
        test_plus;
        test_shift;
        test_ctrl;
        test_keys;
        test_ignore;
        test_back_to_back;
        test_timeout;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
